fifo_rr_arbiter: RTL and testbench

Shares one buffered write port among NUM_REQ requesters using round-robin arbitration with a bounded burst length. The winning requester's beats are written into an internal FIFO. A single consumer drains the FIFO through a rd_en/rdata interface. The block sits in front of the team's FIFO datapath, so several producers can feed one downstream consumer.

---
 rtl/fifo_arb_pkg.sv | 40 ++++
 rtl/arb_sync_fifo.sv | 61 ++++++
 rtl/fifo_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO front end.
//   arb_state_e : arbiter FSM states
//   rr_pick_t   : result of a round-robin search (found flag + index)
//   rr_pick()   : first set request after 'start', wrapping, ending at 'start'
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Requester vectors are zero-padded to this width before searching.
  localparam int unsigned RR_MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Search order is start+1, start+2, ... modulo num_req, with start itself
  // checked last, so the previous holder only wins when nobody else asks.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req_vec,
                                       input logic [2:0]            start,
                                       input int unsigned           num_req);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
      if (k <= num_req) begin
        cand = (32'(start) + k) % num_req;
        if (!res.found && req_vec[cand[2:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_sync_fifo.sv
// Synchronous FIFO behind the arbiter. Pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
//   clk, rst        : clock, async active-high reset
//   wr_en, wr_data  : push (ignored while full)
//   rd_en, rdata    : pop (ignored while empty); rdata registered, 1-cycle latency
//   full, empty     : occupancy flags
//   count           : occupancy 0..DEPTH
module arb_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rdata  <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter with bounded bursts feeding one FIFO and one consumer.
//   clk, rst     : clock, async active-high reset
//   req/req_data : per-requester beat valid and beat (i on [i*DATA_WIDTH +: DATA_WIDTH])
//   ack          : one-hot (or zero) beat-consumed strobe, combinational
//   rd_en/rdata  : consumer pop and registered popped beat
//   full/empty/count : FIFO status
//   owner/busy   : current grant holder, valid while busy
//
// state     | meaning
// ARB_IDLE  | no grant; one cycle spent picking the next owner
// ARB_GRANT | owner's beats are written while it requests and FIFO has room
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int OWN_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  arb_state_e                state;
  logic [OWN_W-1:0]          owner_q;
  logic [OWN_W-1:0]          last_owner_q;
  logic [BURST_W-1:0]        burst_cnt;

  logic [RR_MAX_REQ-1:0]     req_pad;
  logic [2:0]                owner_pad;
  logic [2:0]                last_pad;
  rr_pick_t                  pick_idle;
  rr_pick_t                  pick_rot;

  logic                      own_req;
  logic                      ack_own;
  logic                      release_now;
  logic [DATA_WIDTH-1:0]     wr_data;

  always_comb begin
    req_pad                  = '0;
    req_pad[NUM_REQ-1:0]     = req;
    owner_pad                = '0;
    owner_pad[OWN_W-1:0]     = owner_q;
    last_pad                 = '0;
    last_pad[OWN_W-1:0]      = last_owner_q;
  end

  assign pick_idle = rr_pick(req_pad, last_pad, NUM_REQ);
  assign pick_rot  = rr_pick(req_pad, owner_pad, NUM_REQ);

  // full only stalls: it gates ack but never forces a release.
  assign own_req     = req[owner_q];
  assign ack_own     = (state == ARB_GRANT) && own_req && !full;
  assign release_now = (state == ARB_GRANT) &&
                       (!own_req || (ack_own && (burst_cnt == BURST_W'(MAX_BURST - 1))));

  assign ack     = ack_own ? (NUM_REQ'(1) << owner_q) : '0;
  assign wr_data = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
  assign owner   = owner_q;
  assign busy    = (state == ARB_GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= OWN_W'(NUM_REQ - 1);
      burst_cnt    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_idle.found) begin
            owner_q   <= OWN_W'(pick_idle.idx);
            burst_cnt <= '0;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            burst_cnt <= '0;
            if (pick_rot.found) begin
              // Hand over directly, no idle cycle between owners.
              owner_q <= OWN_W'(pick_rot.idx);
            end else begin
              state        <= ARB_IDLE;
              last_owner_q <= owner_q;
            end
          end else if (ack_own) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  arb_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ack_own),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter (4 requesters, 8-bit beats, depth 4, burst 4).
// Requester i offers beats {A+i, 1..}: requester 0 sends A1, A2, ...
module tb_fifo_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    ack;
  logic             rd_en;
  logic [DW-1:0]    rdata;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic [1:0]       owner;
  logic             busy;

  fifo_rr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .MAX_BURST  (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .rd_en    (rd_en),
    .rdata    (rdata),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  int            left [NR];
  int            seq  [NR];
  logic [DW-1:0] exp_q [$];
  logic [NR-1:0] last_ack;
  logic [1:0]    last_own;
  logic          last_busy;

  logic [3:0] t2_ack [13] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2,
                              4'h1, 4'h1, 4'h1, 4'h1};
  logic [3:0] t3_ack [5]  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
  logic [3:0] t4_ack [13] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8,
                              4'h8, 4'h8, 4'h8, 4'h2};
  logic [7:0] t1_data [3] = '{8'hA1, 8'hA2, 8'hA3};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int i, input int s);
    return {4'(4'hA + i), 4'(s + 1)};
  endfunction

  task automatic update_req();
    for (int i = 0; i < NR; i++) begin
      req[i]              = (left[i] > 0);
      req_data[i*DW +: DW] = beat(i, seq[i]);
    end
  endtask

  // One clock: drive requesters, sample ack just before the edge, then
  // advance acked requesters and score any pop that happened.
  task automatic cycle();
    logic [NR-1:0] a;
    logic          rd;
    logic          emp;
    update_req();
    #1;
    a         = ack;
    rd        = rd_en;
    emp       = empty;
    last_ack  = ack;
    last_own  = owner;
    last_busy = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (a[i]) begin
        exp_q.push_back(beat(i, seq[i]));
        seq[i]++;
        left[i]--;
      end
    end
    if (rd && !emp) begin
      check_val("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_val("rdata_sb", rdata, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rd_en = 1'b0;
    for (int i = 0; i < NR; i++) begin
      left[i] = 0;
      seq[i]  = 0;
    end
    exp_q.delete();
    update_req();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    rd_en    = 1'b0;

    // reset state
    do_reset();
    check_val("rst_ack", ack, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_count", count, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_owner", owner, 0);

    // 1: single requester, three beats, then three pops
    do_reset();
    left[0] = 3;
    cycle();
    check_val("t1_idle_ack", last_ack, 0);
    check_val("t1_idle_busy", last_busy, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val("t1_ack", last_ack, 4'b0001);
    end
    check_val("t1_count", count, 3);
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      check_val("t1_rdata", rdata, t1_data[k]);
    end
    check_val("t1_empty", empty, 1);

    // 2: two requesters saturating, bursts of four alternate without gaps
    do_reset();
    left[0] = 100;
    left[1] = 100;
    rd_en   = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cycle();
      check_val($sformatf("t2_ack%0d", k), last_ack, t2_ack[k]);
      if (k % 4 == 1) check_val($sformatf("t2_owner%0d", k), last_own, (k == 5) ? 1 : 0);
    end

    // 3: FIFO fills, stall holds owner, one pop lets one more beat in
    do_reset();
    left[0] = 6;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_val($sformatf("t3_ack%0d", k), last_ack, t3_ack[k]);
    end
    check_val("t3_full", full, 1);
    check_val("t3_count4", count, 4);
    cycle();
    check_val("t3_stall_ack", last_ack, 0);
    check_val("t3_stall_owner", last_own, 0);
    check_val("t3_stall_busy", last_busy, 1);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    check_val("t3_pop_ack", last_ack, 0);
    check_val("t3_pop_rdata", rdata, 8'hA1);
    check_val("t3_pop_full", full, 0);
    check_val("t3_pop_count", count, 3);
    cycle();
    check_val("t3_reack", last_ack, 4'b0001);
    check_val("t3_refull", full, 1);
    check_val("t3_recount", count, 4);

    // 4: early drop hands over to 2; burst-limit release from 3 wraps to 1
    do_reset();
    left[0] = 2;
    left[2] = 3;
    left[3] = 10;
    rd_en   = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cycle();
      check_val($sformatf("t4_ack%0d", k), last_ack, t4_ack[k]);
      if (k == 4)  check_val("t4_owner2", last_own, 2);
      if (k == 8) begin
        check_val("t4_owner3", last_own, 3);
        left[1] = 5;
        left[2] = 5;
      end
      if (k == 12) check_val("t4_owner1", last_own, 1);
    end

    // 5: asynchronous reset mid-burst
    do_reset();
    left[0] = 6;
    cycle();
    cycle();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    cycle();
    check_val("t5_pre_count", count, 2);
    check_val("t5_pre_rdata", rdata, 8'hA1);
    check_val("t5_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_async_ack", ack, 0);
    check_val("t5_async_busy", busy, 0);
    check_val("t5_async_empty", empty, 1);
    check_val("t5_async_count", count, 0);
    check_val("t5_async_rdata", rdata, 0);
    do_reset();
    left[3] = 1;
    cycle();
    check_val("t5_idle_ack", last_ack, 0);
    cycle();
    check_val("t5_grant3_ack", last_ack, 4'b1000);
    check_val("t5_grant3_owner", last_own, 3);

    // 6: read while empty is ignored; simultaneous read and write at count 2
    do_reset();
    left[0] = 1;
    cycle();
    cycle();
    rd_en = 1'b1;
    cycle();
    check_val("t6_first_rdata", rdata, 8'hA1);
    cycle();
    check_val("t6_empty_rdata", rdata, 8'hA1);
    check_val("t6_empty_flag", empty, 1);
    check_val("t6_empty_count", count, 0);
    rd_en   = 1'b0;
    left[0] = 3;
    cycle();
    check_val("t6_idle_ack", last_ack, 0);
    cycle();
    cycle();
    check_val("t6_count2", count, 2);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    check_val("t6_rw_ack", last_ack, 4'b0001);
    check_val("t6_rw_count", count, 2);
    check_val("t6_rw_rdata", rdata, 8'hA2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
